fpx_mul_pipe: RTL and testbench

FPX_MUL_PIPE -- requirements
Module: fpx_mul_pipe

---
 rtl/fpx_mul_pipe.sv | 154 +++++++++++++++
 tb/tb_fpx_mul_pipe.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fpx_mul_pipe.sv
// Three-stage {sign, exp, frac} multiplier with round-to-nearest-even.
// No subnormals or Inf/NaN; overflow saturates, underflow flushes to zero.
module fpx_mul_pipe #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3,
    parameter int BIAS  = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_data,
    output logic                   out_ovf,
    output logic                   out_unf,
    output logic                   out_zero
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam int XW = EXP_W + 3;
    localparam logic [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);

    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // S1: unpack and multiply
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             s1_zero_d;
    logic [EW-1:0]    s1_e_d;
    logic [PW-1:0]    s1_p_d;

    assign sa = a[W-1];
    assign sb = b[W-1];
    assign ea = a[W-2 -: EXP_W];
    assign eb = b[W-2 -: EXP_W];
    assign fa = a[MAN_W-1:0];
    assign fb = b[MAN_W-1:0];

    assign s1_zero_d = (ea == '0) || (eb == '0);
    assign s1_e_d    = {2'b00, ea} + {2'b00, eb} - EW'(BIAS);
    assign s1_p_d    = PW'({1'b1, fa}) * PW'({1'b1, fb});

    logic          s1_valid;
    logic          s1_sign;
    logic          s1_zero;
    logic [EW-1:0] s1_e;
    logic [PW-1:0] s1_p;

    // S2: normalise, round, classify
    logic             msb;
    logic [MAN_W-1:0] frac;
    logic             guard;
    logic             sticky;
    logic             rnd;
    logic [MAN_W:0]   fr;
    logic [XW-1:0]    e_f;
    logic             ovf;
    logic             unf;

    assign msb    = s1_p[PW-1];
    assign frac   = msb ? s1_p[PW-2 -: MAN_W] : s1_p[PW-3 -: MAN_W];
    assign guard  = msb ? s1_p[PW-2-MAN_W] : s1_p[PW-3-MAN_W];
    assign sticky = msb ? |s1_p[PW-3-MAN_W:0] : |s1_p[PW-4-MAN_W:0];
    assign rnd    = guard && (sticky || frac[0]);
    assign fr     = {1'b0, frac} + {{MAN_W{1'b0}}, rnd};

    // A rounding carry leaves fr = 1.000..., so its low bits are already 0
    assign e_f = {s1_e[EW-1], s1_e}
               + {{(XW-1){1'b0}}, msb}
               + {{(XW-1){1'b0}}, fr[MAN_W]};

    assign ovf = !e_f[XW-1] && (e_f > EMAX);
    assign unf = e_f[XW-1] || (e_f == '0);

    logic [EXP_W-1:0] n_exp;
    logic [MAN_W-1:0] n_frac;
    logic             n_ovf;
    logic             n_unf;
    logic             n_zero;

    always_comb begin
        n_exp  = '0;
        n_frac = '0;
        n_ovf  = 1'b0;
        n_unf  = 1'b0;
        n_zero = 1'b0;
        if (s1_zero) begin
            n_zero = 1'b1;
        end else if (ovf) begin
            n_exp  = '1;
            n_frac = '1;
            n_ovf  = 1'b1;
        end else if (unf) begin
            n_unf  = 1'b1;
            n_zero = 1'b1;
        end else begin
            n_exp  = e_f[EXP_W-1:0];
            n_frac = fr[MAN_W-1:0];
        end
    end

    logic         s2_valid;
    logic [W-1:0] s2_data;
    logic         s2_ovf;
    logic         s2_unf;
    logic         s2_zero;

    // All stages share one enable so a stall freezes the whole pipe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_zero   <= 1'b0;
            s1_e      <= '0;
            s1_p      <= '0;
            s2_valid  <= 1'b0;
            s2_data   <= '0;
            s2_ovf    <= 1'b0;
            s2_unf    <= 1'b0;
            s2_zero   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
            out_zero  <= 1'b0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s1_sign   <= sa ^ sb;
            s1_zero   <= s1_zero_d;
            s1_e      <= s1_e_d;
            s1_p      <= s1_p_d;
            s2_valid  <= s1_valid;
            s2_data   <= {s1_sign, n_exp, n_frac};
            s2_ovf    <= n_ovf;
            s2_unf    <= n_unf;
            s2_zero   <= n_zero;
            out_valid <= s2_valid;
            out_data  <= s2_data;
            out_ovf   <= s2_ovf;
            out_unf   <= s2_unf;
            out_zero  <= s2_zero;
        end
    end

endmodule

// File: tb/tb_fpx_mul_pipe.sv
// Directed-vector bench for fpx_mul_pipe at E4M3, bias 7.
// Covers rounding, saturation, flush, stalls and mid-flight reset.
module tb_fpx_mul_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_ovf;
    logic       out_unf;
    logic       out_zero;

    fpx_mul_pipe #(.EXP_W(4), .MAN_W(3), .BIAS(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       o;
        logic       u;
        logic       z;
    } vec_t;

    localparam int NV = 20;
    vec_t tv [NV];

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input vec_t v);
        check(name, {21'd0, out_data, out_ovf, out_unf, out_zero},
              {21'd0, v.d, v.o, v.u, v.z});
    endtask

    task automatic apply_one(input int idx);
        int n;
        @(negedge clk);
        a         = tv[idx].a;
        b         = tv[idx].b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        check($sformatf("latency[%0d]", idx), n, 3);
        check_out($sformatf("vec[%0d] %h*%h", idx, tv[idx].a, tv[idx].b),
                  tv[idx]);
    endtask

    initial begin
        int sent;
        int recv;
        int cyc;
        int n;

        tv[0]  = '{8'h3C, 8'h3C, 8'h41, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{8'h39, 8'h3C, 8'h3E, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{8'h7F, 8'h7F, 8'h7F, 1'b1, 1'b0, 1'b0};
        tv[3]  = '{8'h08, 8'h88, 8'h80, 1'b0, 1'b1, 1'b1};
        tv[4]  = '{8'h00, 8'hBC, 8'h80, 1'b0, 1'b0, 1'b1};
        tv[5]  = '{8'h38, 8'h38, 8'h38, 1'b0, 1'b0, 1'b0};
        tv[6]  = '{8'hB8, 8'h38, 8'hB8, 1'b0, 1'b0, 1'b0};
        tv[7]  = '{8'h40, 8'h40, 8'h48, 1'b0, 1'b0, 1'b0};
        tv[8]  = '{8'h39, 8'h3E, 8'h40, 1'b0, 1'b0, 1'b0};
        tv[9]  = '{8'h3A, 8'h3A, 8'h3C, 1'b0, 1'b0, 1'b0};
        tv[10] = '{8'h3F, 8'h3F, 8'h46, 1'b0, 1'b0, 1'b0};
        tv[11] = '{8'h78, 8'h38, 8'h78, 1'b0, 1'b0, 1'b0};
        tv[12] = '{8'h78, 8'h40, 8'h7F, 1'b1, 1'b0, 1'b0};
        tv[13] = '{8'h79, 8'h3E, 8'h7F, 1'b1, 1'b0, 1'b0};
        tv[14] = '{8'h08, 8'h38, 8'h08, 1'b0, 1'b0, 1'b0};
        tv[15] = '{8'h08, 8'h30, 8'h00, 1'b0, 1'b1, 1'b1};
        tv[16] = '{8'h0C, 8'h34, 8'h09, 1'b0, 1'b0, 1'b0};
        tv[17] = '{8'h80, 8'h7F, 8'h80, 1'b0, 1'b0, 1'b1};
        tv[18] = '{8'h05, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b1};
        tv[19] = '{8'hFF, 8'h7F, 8'hFF, 1'b1, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 0);
        check("reset outputs", {21'd0, out_data, out_ovf, out_unf, out_zero}, 0);
        check("reset in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++)
            apply_one(i);

        // Five back-to-back pairs with out_ready low for four cycles
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (3) @(negedge clk);
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 5 && cyc < 60) begin
            out_ready = !(cyc >= 4 && cyc <= 7);
            in_valid  = (sent < 5);
            if (sent < 5) begin
                a = tv[sent].a;
                b = tv[sent].b;
            end
            #1;
            if (out_valid && !out_ready)
                check($sformatf("stall in_ready c%0d", cyc), 32'(in_ready), 0);
            if (out_valid && !out_ready)
                check_out($sformatf("stall hold c%0d", cyc), tv[recv]);
            if (out_valid && out_ready) begin
                check_out($sformatf("stream[%0d]", recv), tv[recv]);
                recv++;
            end
            if (in_valid && in_ready)
                sent++;
            @(negedge clk);
            cyc++;
        end
        check("stream count", recv, 5);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid)
                n++;
        end
        check("stream no extra", n, 0);

        // Reset with one result at the output and two in flight
        for (int i = 0; i < 3; i++) begin
            a        = tv[i + 5].a;
            b        = tv[i + 5].b;
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("pre-reset out_valid", 32'(out_valid), 1);
        rst = 1'b1;
        #1;
        check("rst out_valid", 32'(out_valid), 0);
        check("rst outputs", {21'd0, out_data, out_ovf, out_unf, out_zero}, 0);
        check("rst in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst      = 1'b0;
        a        = tv[0].a;
        b        = tv[0].b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("post-rst latency", n, 3);
        check_out("post-rst result", tv[0]);
        @(posedge clk);
        #1;
        n = 0;
        repeat (4) begin
            if (out_valid)
                n++;
            @(posedge clk);
            #1;
        end
        check("post-rst no stale", n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
